cp_insert_tx: RTL

CP_INSERT_TX -- requirements
Module: cp_insert_tx

---
 rtl/cp_tx_pkg.sv | 17 +
 rtl/tx_symbol_ram.sv | 30 +++
 rtl/cp_insert_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cp_tx_pkg.sv
// Shared definitions for the cyclic-prefix inserter: read FSM states and SSB
// cadence (used only when CP_INSERT_SSB_SYNC_EN is defined).
package cp_tx_pkg;

    localparam int unsigned SYMS_BTWN_SSB = 280;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_e;

    function automatic logic [8:0] ssb_cnt_next(input logic [8:0] cnt);
        return (cnt == 9'(SYMS_BTWN_SSB - 1)) ? 9'd0 : cnt + 9'd1;
    endfunction

endpackage

// File: rtl/tx_symbol_ram.sv
// Simple dual-port symbol buffer: one write port, one read port with a
// registered, enable-gated read (data holds while re_i is low).
module tx_symbol_ram #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1 << AW) - 1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cp_insert_tx.sv
// Cyclic-prefix inserter: ping-pong buffers IFFT symbols and replays the tail
// as CP ahead of the body. Optional SSB tagging under CP_INSERT_SSB_SYNC_EN.
module cp_insert_tx
    import cp_tx_pkg::*;
#(
    parameter int IN_DW  = 32,
    parameter int NFFT   = 8,
    parameter int CP_LEN = 18
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    output logic             s_axis_in_tready,
    input  logic             symbol_start_i,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    input  logic             m_axis_out_tready,
    output logic             m_axis_out_tlast,
    output logic             symbol_start_o,
    output logic             cp_o
`ifdef CP_INSERT_SSB_SYNC_EN
    ,
    input  logic             SSB_start_i,
    output logic             SSB_start_o
`endif
);

    localparam int              FFT_LEN  = 1 << NFFT;
    localparam logic [NFFT-1:0] CP_FIRST = NFFT'(FFT_LEN - CP_LEN);
    localparam logic [NFFT-1:0] CP_LAST  = NFFT'(CP_LEN - 1);
    localparam logic [NFFT-1:0] IDX_LAST = '1;

    // ---------------- write side ----------------
    logic            rdy_q;
    logic            sync_seen_q, sync_seen_d;
    logic            wr_bank_q, wr_bank_d;
    logic [NFFT-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]      full_q, full_d;
    logic            in_acc, wr_en, wr_last;
    logic [NFFT-1:0] wr_idx;

    // ---------------- read side -----------------
    rd_state_e       state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [NFFT-1:0] rd_cnt_q, rd_cnt_d;
    logic [NFFT-1:0] rd_idx;
    logic            vld_q, vld_d;
    logic            sos_q, sos_d;
    logic            cp_q, cp_d;
    logic            last_q, last_d;
    logic            out_bank_q, out_bank_d;
    logic            advance, fire, issue_sos, bank_rel;
    logic [IN_DW-1:0] ram_rdata;

    // The writer always moves to the other bank once one fills; that bank can
    // only still be full if both are, so checking the current bank suffices.
    assign s_axis_in_tready = rdy_q && !full_q[wr_bank_q];
    assign in_acc  = s_axis_in_tvalid && s_axis_in_tready;
    assign wr_en   = in_acc && (sync_seen_q || symbol_start_i);
    assign wr_idx  = symbol_start_i ? '0 : wr_idx_q;
    assign wr_last = wr_en && (wr_idx == IDX_LAST);

    assign bank_rel = vld_q && m_axis_out_tready && last_q;

    always_comb begin
        sync_seen_d = sync_seen_q || (in_acc && symbol_start_i);
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        if (wr_en) begin
            wr_idx_d = wr_idx + 1'b1;
            if (wr_last) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        if (bank_rel) begin
            full_d[out_bank_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdy_q       <= 1'b0;
            sync_seen_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
        end else begin
            rdy_q       <= 1'b1;
            sync_seen_q <= sync_seen_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            full_q      <= full_d;
        end
    end

    // A new RAM read is issued only when the output register is free or drains
    // this cycle, so the registered RAM output doubles as the output stage.
    assign advance   = !vld_q || m_axis_out_tready;
    assign fire      = (state_q != RD_IDLE) && advance;
    assign issue_sos = fire && (state_q == RD_CP) && (rd_cnt_q == '0);
    assign rd_idx    = (state_q == RD_CP) ? (CP_FIRST + rd_cnt_q) : rd_cnt_q;

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = RD_CP;
                    rd_cnt_d = '0;
                end
            end
            RD_CP: begin
                if (fire) begin
                    if (rd_cnt_q == CP_LAST) begin
                        state_d  = RD_BODY;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            RD_BODY: begin
                if (fire) begin
                    if (rd_cnt_q == IDX_LAST) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_cnt_d  = '0;
                        state_d   = full_q[~rd_bank_q] ? RD_CP : RD_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        vld_d      = vld_q;
        sos_d      = sos_q;
        cp_d       = cp_q;
        last_d     = last_q;
        out_bank_d = out_bank_q;
        if (advance) begin
            vld_d      = fire;
            sos_d      = issue_sos;
            cp_d       = fire && (state_q == RD_CP);
            last_d     = fire && (state_q == RD_BODY) && (rd_cnt_q == IDX_LAST);
            out_bank_d = rd_bank_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            vld_q      <= 1'b0;
            sos_q      <= 1'b0;
            cp_q       <= 1'b0;
            last_q     <= 1'b0;
            out_bank_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
            vld_q      <= vld_d;
            sos_q      <= sos_d;
            cp_q       <= cp_d;
            last_q     <= last_d;
            out_bank_q <= out_bank_d;
        end
    end

    tx_symbol_ram #(
        .DW(IN_DW),
        .AW(NFFT + 1)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (wr_en),
        .waddr_i({wr_bank_q, wr_idx}),
        .wdata_i(s_axis_in_tdata),
        .re_i   (fire),
        .raddr_i({rd_bank_q, rd_idx}),
        .rdata_o(ram_rdata)
    );

    assign m_axis_out_tdata  = vld_q ? ram_rdata : '0;
    assign m_axis_out_tvalid = vld_q;
    assign m_axis_out_tlast  = last_q;
    assign symbol_start_o    = sos_q;
    assign cp_o              = cp_q;

`ifdef CP_INSERT_SSB_SYNC_EN
    // Each bank carries a tag saying whether its symbol is number 0 of the SSB
    // period; the tag is fixed when the bank fills and read back at its CP start.
    logic [8:0] sym_cnt_q, sym_cnt_d, sym_num;
    logic [1:0] ssb_tag_q, ssb_tag_d;
    logic       ssb_q, ssb_d;

    always_comb begin
        sym_num   = (in_acc && symbol_start_i && SSB_start_i) ? '0 : sym_cnt_q;
        sym_cnt_d = sym_num;
        ssb_tag_d = ssb_tag_q;
        if (wr_last) begin
            sym_cnt_d            = ssb_cnt_next(sym_num);
            ssb_tag_d[wr_bank_q] = (sym_num == '0);
        end
        ssb_d = ssb_q;
        if (advance) begin
            ssb_d = issue_sos && ssb_tag_q[rd_bank_q];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sym_cnt_q <= '0;
            ssb_tag_q <= '0;
            ssb_q     <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            ssb_tag_q <= ssb_tag_d;
            ssb_q     <= ssb_d;
        end
    end

    assign SSB_start_o = ssb_q;
`endif

endmodule
